// File: rtl/memory_responder.sv
// Word-addressed RAM answering the CPU memory port, with a post-reset clear
// sequencer and a host load port that streams a program image into memory.
module memory_responder #(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_ADDR_SIZE = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [MEM_ADDR_SIZE-1:0] mem_address,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [WORD_SIZE-1:0]     mem_write_data,
  output logic [WORD_SIZE-1:0]     mem_read_data,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [WORD_SIZE-1:0]     load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  output logic [MEM_ADDR_SIZE:0]   load_count,
  output logic                     busy,
  output logic                     access_error
);

  localparam int DEPTH = 1 << MEM_ADDR_SIZE;
  localparam logic [MEM_ADDR_SIZE-1:0] LAST_ADDR = '1;
  localparam logic [MEM_ADDR_SIZE-1:0] PTR_ONE   = 1;
  localparam logic [MEM_ADDR_SIZE:0]   CNT_ONE   = 1;

  typedef enum logic [1:0] {CLEAR, READY, LOAD} state_t;

  state_t                   state;
  logic [WORD_SIZE-1:0]     ram [DEPTH];
  logic [MEM_ADDR_SIZE-1:0] clear_ptr;
  logic [MEM_ADDR_SIZE-1:0] load_ptr;
  logic                     cpu_strobe;
  logic                     transfer;
  logic                     ram_we;
  logic [MEM_ADDR_SIZE-1:0] ram_addr;
  logic [WORD_SIZE-1:0]     ram_wdata;

  assign cpu_strobe = mem_read | mem_write;
  // A restart in LOAD takes priority over a word offered in the same cycle.
  assign transfer   = (state == LOAD) && load_valid && !load_start;
  assign load_ready = (state == LOAD);
  assign busy       = (state != READY);

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = clear_ptr;
    ram_wdata = '0;
    case (state)
      CLEAR: ram_we = 1'b1;
      READY: begin
        if (mem_write) begin
          ram_we    = 1'b1;
          ram_addr  = mem_address;
          ram_wdata = mem_write_data;
        end
      end
      LOAD: begin
        if (transfer) begin
          ram_we    = 1'b1;
          ram_addr  = load_ptr;
          ram_wdata = load_data;
        end
      end
      default: ram_we = 1'b0;
    endcase
  end

  // Array contents are deliberately not reset; the CLEAR sequence zeroes them.
  always_ff @(posedge clock) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= CLEAR;
      clear_ptr     <= '0;
      load_ptr      <= '0;
      load_count    <= '0;
      mem_read_data <= '0;
      access_error  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clear_ptr <= clear_ptr + PTR_ONE;
          if (cpu_strobe) access_error <= 1'b1;
          if (clear_ptr == LAST_ADDR) state <= READY;
        end
        READY: begin
          if (mem_read && mem_write) access_error <= 1'b1;
          else if (mem_read) mem_read_data <= ram[mem_address];
          if (load_start) begin
            state      <= LOAD;
            load_ptr   <= '0;
            load_count <= '0;
          end
        end
        LOAD: begin
          if (cpu_strobe) access_error <= 1'b1;
          if (load_start) begin
            load_ptr   <= '0;
            load_count <= '0;
          end else if (transfer) begin
            load_count <= load_count + CNT_ONE;
            // Hold the pointer at the top address so it never wraps to 0.
            if (load_ptr != LAST_ADDR) load_ptr <= load_ptr + PTR_ONE;
            if (load_last || (load_ptr == LAST_ADDR)) state <= READY;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: clear, host loads, CPU access,
// access errors and reset during a load.
module tb_memory_responder;

  logic        clock;
  logic        reset;
  logic [7:0]  mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic        load_start;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic [8:0]  load_count;
  logic        busy;
  logic        access_error;

  int errors = 0;
  int checks = 0;

  memory_responder #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8)) dut (
    .clock(clock), .reset(reset),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_count(load_count),
    .busy(busy), .access_error(access_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cpu_read(input logic [7:0] addr, output logic [15:0] data);
    mem_address = addr;
    mem_read    = 1'b1;
    @(negedge clock);
    mem_read    = 1'b0;
    data        = mem_read_data;
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [15:0] data);
    mem_address    = addr;
    mem_write_data = data;
    mem_write      = 1'b1;
    @(negedge clock);
    mem_write      = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (busy && cycles < 1000) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] words [4];
    int cycles;
    int nonzero;

    words[0] = 16'h1234; words[1] = 16'hABCD; words[2] = 16'h0001; words[3] = 16'hFFFF;
    reset = 1'b0; mem_address = '0; mem_read = 0; mem_write = 0; mem_write_data = '0;
    load_start = 0; load_valid = 0; load_data = '0; load_last = 0;

    repeat (3) @(negedge clock);
    check("rst_busy", busy, 1);
    check("rst_rdata", mem_read_data, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_load_count", load_count, 0);
    check("rst_access_error", access_error, 0);

    // Clear sequence: exactly 256 cycles of busy.
    reset = 1'b1;
    wait_ready(cycles);
    check("clear_cycles", cycles, 256);

    nonzero = 0;
    for (int a = 0; a < 256; a++) begin
      cpu_read(a[7:0], rd);
      if (rd !== 16'h0000) nonzero++;
    end
    check("clear_all_zero", nonzero, 0);
    check("clear_no_error", access_error, 0);

    // Four-word load ending on load_last.
    start_load();
    check("load_busy", busy, 1);
    check("load_ready_high", load_ready, 1);
    check("load_count_start", load_count, 0);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = (i == 3);
      @(negedge clock);
    end
    load_valid = 0; load_last = 0;
    check("load4_count", load_count, 4);
    check("load4_busy", busy, 0);
    check("load4_ready_low", load_ready, 0);
    for (int i = 0; i < 4; i++) begin
      cpu_read(i[7:0], rd);
      check($sformatf("load4_rd%0d", i), rd, {16'h0, words[i]});
    end

    // Valid toggling: idle cycles must not write or advance the address.
    start_load();
    for (int i = 0; i < 8; i++) begin
      load_valid = (i % 2 == 1);
      load_data  = (i % 2 == 1) ? 16'h1000 + 16'(i / 2) : 16'hDEAD;
      load_last  = (i == 7);
      @(negedge clock);
    end
    load_valid = 0; load_last = 0;
    check("toggle_count", load_count, 4);
    check("toggle_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      cpu_read(i[7:0], rd);
      check($sformatf("toggle_rd%0d", i), rd, 16'h1000 + i);
    end

    // Full 256-word load with no load_last exits after address 255.
    start_load();
    for (int i = 0; i < 256; i++) begin
      load_valid = 1'b1;
      load_data  = 16'hC000 + 16'(i);
      if (i == 255) check("full_busy_before_last", busy, 1);
      @(negedge clock);
    end
    load_valid = 0;
    check("full_count", load_count, 256);
    check("full_busy", busy, 0);
    cpu_read(8'h00, rd);  check("full_rd0", rd, 16'hC000);
    cpu_read(8'h80, rd);  check("full_rd128", rd, 16'hC080);
    cpu_read(8'hFF, rd);  check("full_rd255", rd, 16'hC0FF);
    check("full_count_hold", load_count, 256);

    // CPU write then read on the next cycle; value holds through idle cycles.
    cpu_write(8'h10, 16'h5A5A);
    cpu_read(8'h10, rd);
    check("wr_rd_next", rd, 16'h5A5A);
    repeat (3) @(negedge clock);
    check("rd_hold", mem_read_data, 16'h5A5A);
    check("no_error_yet", access_error, 0);

    // Simultaneous read and write: write lands, read data held, error set.
    mem_address = 8'h20; mem_write_data = 16'h7777; mem_read = 1; mem_write = 1;
    @(negedge clock);
    mem_read = 0; mem_write = 0;
    check("both_error", access_error, 1);
    check("both_rdata_held", mem_read_data, 16'h5A5A);
    cpu_read(8'h20, rd);
    check("both_write_landed", rd, 16'h7777);

    // Reset in the middle of a load aborts and the clear re-zeroes memory.
    start_load();
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 16'hBEEF;
      @(negedge clock);
    end
    reset = 1'b0;
    #1;
    check("midload_rst_busy", busy, 1);
    check("midload_rst_ready", load_ready, 0);
    check("midload_rst_count", load_count, 0);
    check("midload_rst_error", access_error, 0);
    load_valid = 0;
    @(negedge clock);
    reset = 1'b1;
    // A CPU strobe during CLEAR is ignored but flagged.
    mem_address = 8'h05; mem_read = 1'b1;
    @(negedge clock);
    mem_read = 1'b0;
    wait_ready(cycles);
    check("reclear_cycles", cycles + 1, 256);
    check("clear_strobe_error", access_error, 1);
    check("clear_strobe_rdata", mem_read_data, 0);
    for (int i = 0; i < 3; i++) begin
      cpu_read(i[7:0], rd);
      check($sformatf("reclear_rd%0d", i), rd, 0);
    end
    cpu_read(8'h20, rd);
    check("reclear_rd20", rd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
